// File: rtl/ldpc_pkg.sv
// Shared LDPC datapath types: LLR word width, LLR word type and the negative-zero code.
package ldpc_pkg;

  localparam int unsigned LLR_WIDTH = 6;

  typedef logic [LLR_WIDTH-1:0] llr_t;

  localparam llr_t NEG_ZERO = {1'b1, {(LLR_WIDTH-1){1'b0}}};

  // Width-generic negative-zero test, usable for any DATA_WIDTH up to 32.
  function automatic logic is_neg_zero(input logic [31:0] word, input int unsigned width);
    logic [31:0] code_s;
    code_s = 32'd1 << (width - 32'd1);
    return (word == code_s);
  endfunction

endpackage

// File: rtl/sm2tc_core.sv
// Purely combinational sign-magnitude to two's-complement conversion of one word.
module sm2tc_core
  import ldpc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = LLR_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] inp,
  output logic [DATA_WIDTH-1:0] out
);

  logic                  sign_s;
  logic [DATA_WIDTH-2:0] mag_s;
  logic [DATA_WIDTH-1:0] neg_s;

  assign sign_s = inp[DATA_WIDTH-1];
  assign mag_s  = inp[DATA_WIDTH-2:0];

  // Negating the zero-extended magnitude keeps -2^(N-1) unreachable and maps negative zero to 0.
  assign neg_s = ~{1'b0, mag_s} + {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  // Select passthrough for positive words, negated magnitude for negative words.
  always_comb begin
    out = inp;
    if (sign_s) begin
      out = neg_s;
    end else begin
      out = inp;
    end
  end

endmodule

// File: rtl/s_to_t.sv
// Sign-magnitude to two's-complement LLR converter with a zero-latency output
// and a one-cycle registered copy carrying valid and a negative-zero flag.
module s_to_t
  import ldpc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = LLR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] inp,
  input  logic                  in_valid,
  output logic [DATA_WIDTH-1:0] out,
  output logic [DATA_WIDTH-1:0] out_q,
  output logic                  out_valid,
  output logic                  neg_zero
);

  logic [DATA_WIDTH-1:0] conv_s;
  logic                  nz_s;
  logic [DATA_WIDTH-1:0] out_q_r;
  logic                  out_valid_r;
  logic                  neg_zero_r;

  sm2tc_core #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_core (
    .inp (inp),
    .out (conv_s)
  );

  assign out = conv_s;
  assign nz_s = is_neg_zero(32'(inp), DATA_WIDTH);

  // Capture stage: valid follows in_valid every edge, data and flag only on valid cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q_r     <= {DATA_WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      neg_zero_r  <= 1'b0;
    end else begin
      out_valid_r <= in_valid;
      if (in_valid) begin
        out_q_r    <= conv_s;
        neg_zero_r <= nz_s;
      end
    end
  end

  assign out_q     = out_q_r;
  assign out_valid = out_valid_r;
  assign neg_zero  = neg_zero_r;

endmodule

// File: tb/tb_s_to_t.sv
// Self-checking bench for s_to_t: exhaustive combinational sweeps at widths 6 and 4,
// scoreboarded registered path, negative-zero flag and asynchronous reset behaviour.
module tb_s_to_t;

  logic       clk;
  logic       rst_n;
  logic [5:0] inp6;
  logic       iv6;
  logic [5:0] out6;
  logic [5:0] q6;
  logic       ov6;
  logic       nz6;
  logic [3:0] inp4;
  logic       iv4;
  logic [3:0] out4;
  logic [3:0] q4;
  logic       ov4;
  logic       nz4;

  int total;
  int bad;

  logic [6:0] sb[$];
  logic [5:0] hold_q;
  logic       hold_nz;

  s_to_t #(.DATA_WIDTH(6)) dut6 (
    .clk       (clk),
    .rst_n     (rst_n),
    .inp       (inp6),
    .in_valid  (iv6),
    .out       (out6),
    .out_q     (q6),
    .out_valid (ov6),
    .neg_zero  (nz6)
  );

  s_to_t #(.DATA_WIDTH(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .inp       (inp4),
    .in_valid  (iv4),
    .out       (out4),
    .out_q     (q4),
    .out_valid (ov4),
    .neg_zero  (nz4)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Arithmetic reference: negative words become 2^n - magnitude, reduced mod 2^n.
  function automatic int conv(input int x, input int n);
    int half;
    int mag;
    half = 1 << (n - 1);
    mag  = x % half;
    if (x >= half) return ((1 << n) - mag) % (1 << n);
    return x;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [5:0] d);
    logic [6:0] e;
    @(negedge clk);
    iv6  = v;
    inp6 = d;
    if (v) sb.push_back({(d == 6'b100000), 6'(conv(int'(d), 6))});
    @(posedge clk);
    #1;
    check("out_valid", 32'(ov6), 32'(v));
    if (ov6) begin
      check("sb_size", sb.size(), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("out_q", 32'(q6), 32'(e[5:0]));
        check("neg_zero", 32'(nz6), 32'(e[6]));
        hold_q  = e[5:0];
        hold_nz = e[6];
      end
    end else begin
      check("hold_q", 32'(q6), 32'(hold_q));
      check("hold_nz", 32'(nz6), 32'(hold_nz));
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    hold_q  = 6'd0;
    hold_nz = 1'b0;
    rst_n = 1'b0;
    iv6   = 1'b0;
    inp6  = 6'd0;
    iv4   = 1'b0;
    inp4  = 4'd0;

    #5;
    check("rst_q", 32'(q6), 32'd0);
    check("rst_valid", 32'(ov6), 32'd0);
    check("rst_nz", 32'(nz6), 32'd0);
    check("rst_q4", 32'(q4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 64; i++) begin
      inp6 = 6'(i);
      #10;
      check("sweep6", 32'(out6), 32'(conv(i, 6)));
    end
    for (int i = 0; i < 16; i++) begin
      inp4 = 4'(i);
      #10;
      check("sweep4", 32'(out4), 32'(conv(i, 4)));
    end

    inp6 = 6'b000101; #10; check("spot_p5", 32'(out6), 32'b000101);
    inp6 = 6'b100101; #10; check("spot_m5", 32'(out6), 32'b111011);
    inp6 = 6'b111111; #10; check("spot_m31", 32'(out6), 32'b100001);
    inp6 = 6'b100000; #10; check("spot_nz", 32'(out6), 32'b000000);
    inp4 = 4'b1011;   #10; check("spot4_m3", 32'(out4), 32'b1101);
    inp4 = 4'b1000;   #10; check("spot4_nz", 32'(out4), 32'b0000);

    step(1'b1, 6'b100001);
    check("q_m1", 32'(q6), 32'b111111);
    step(1'b0, 6'b010101);
    check("q_hold_m1", 32'(q6), 32'b111111);

    step(1'b1, 6'b100000);
    check("nz_set", 32'(nz6), 32'd1);
    step(1'b1, 6'b000000);
    check("nz_clr", 32'(nz6), 32'd0);

    for (int i = 0; i < 24; i++) begin
      step(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)));
    end

    step(1'b1, 6'b111001);
    @(negedge clk);
    iv6  = 1'b0;
    inp6 = 6'b100011;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_q", 32'(q6), 32'd0);
    check("arst_valid", 32'(ov6), 32'd0);
    check("arst_nz", 32'(nz6), 32'd0);
    check("arst_out", 32'(out6), 32'(conv(int'(inp6), 6)));
    hold_q  = 6'd0;
    hold_nz = 1'b0;
    @(posedge clk);
    #1;
    check("arst_held", 32'(q6), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 6'b101010);
    step(1'b1, 6'b100010);
    check("post_rst_q", 32'(q6), 32'b111110);

    step(1'b0, 6'b000000);
    check("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
